// File: rtl/bus_arbiter4.sv
// bus_arbiter4: round-robin arbiter sharing one 16-bit result bus among four
// requesters, with a mux4way16 selecting the owner's data.
// Optional feature macro: ARB_TIMEOUT_EN (hold-time preemption after MAX_HOLD cycles).

module mux4way16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [1:0]  sel,
  output logic [15:0] out
);

  // 4:1 word select
  always_comb begin
    out = a;
    case (sel)
      2'd0: out = a;
      2'd1: out = b;
      2'd2: out = c;
      2'd3: out = d;
      default: out = a;
    endcase
  end

endmodule

module bus_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [15:0] din0,
  input  logic [15:0] din1,
  input  logic [15:0] din2,
  input  logic [15:0] din3,
  output logic [3:0]  gnt,
  output logic [1:0]  gnt_idx,
  output logic        busy,
  output logic [15:0] out,
  output logic        preempt
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = {CNT_W{1'b1}};
`ifdef ARB_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_n;
  logic [3:0]       gnt_n;
  logic [1:0]       gnt_idx_n;
  logic             busy_n;
  logic             preempt_n;
  logic [1:0]       last, last_n;
  logic [CNT_W-1:0] hold_cnt, hold_n;
  logic [3:0]       owner_oh;
  logic [3:0]       others;
  logic [2:0]       pick_any;
  logic [2:0]       pick_oth;
  logic             timeout;
  logic [15:0]      mux_out;

  // First requester in mask after position 'after', wrapping; {found, idx}
  function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] after);
    logic [2:0] r;
    logic [1:0] i;
    r = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      i = after + 2'(k);
      if (!r[2] && mask[i]) r = {1'b1, i};
    end
    return r;
  endfunction

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      gnt_idx  <= 2'd0;
      busy     <= 1'b0;
      preempt  <= 1'b0;
      last     <= 2'd3;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      gnt_idx  <= gnt_idx_n;
      busy     <= busy_n;
      preempt  <= preempt_n;
      last     <= last_n;
      hold_cnt <= hold_n;
    end
  end

  // Next-state: grant, release/hand-over, hold counting and timeout preemption
  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    gnt_idx_n = gnt_idx;
    busy_n    = busy;
    preempt_n = 1'b0;
    last_n    = last;
    hold_n    = hold_cnt;
    owner_oh  = 4'b0001 << gnt_idx;
    others    = req & ~owner_oh;
    pick_any  = rr_pick(req, last);
    pick_oth  = rr_pick(others, gnt_idx);
    timeout   = TO_EN && (hold_cnt == HOLD_LAST) && (others != 4'b0000);

    case (state)
      IDLE: begin
        if (pick_any[2]) begin
          state_n   = BUSY;
          gnt_n     = 4'b0001 << pick_any[1:0];
          gnt_idx_n = pick_any[1:0];
          busy_n    = 1'b1;
          last_n    = pick_any[1:0];
          hold_n    = '0;
        end
      end
      BUSY: begin
        if (!req[gnt_idx]) begin
          // owner released: hand over back-to-back or go idle
          if (pick_oth[2]) begin
            gnt_n     = 4'b0001 << pick_oth[1:0];
            gnt_idx_n = pick_oth[1:0];
            last_n    = pick_oth[1:0];
            hold_n    = '0;
          end else begin
            state_n   = IDLE;
            gnt_n     = 4'b0000;
            gnt_idx_n = 2'd0;
            busy_n    = 1'b0;
            last_n    = gnt_idx;
            hold_n    = '0;
          end
        end else if (timeout) begin
          // revoke: old owner becomes lowest priority
          gnt_n     = 4'b0001 << pick_oth[1:0];
          gnt_idx_n = pick_oth[1:0];
          last_n    = gnt_idx;
          hold_n    = '0;
          preempt_n = 1'b1;
        end else if (hold_cnt != HOLD_SAT) begin
          hold_n = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n   = IDLE;
        gnt_n     = 4'b0000;
        gnt_idx_n = 2'd0;
        busy_n    = 1'b0;
      end
    endcase
  end

  mux4way16 u_mux (
    .a   (din0),
    .b   (din1),
    .c   (din2),
    .d   (din3),
    .sel (gnt_idx),
    .out (mux_out)
  );

  // Bus is driven only while a grant is held
  assign out = busy ? mux_out : 16'h0000;

endmodule

// File: tb/tb_bus_arbiter4.sv
// tb_bus_arbiter4: directed and randomized checks of bus_arbiter4 against a
// behavioural round-robin model. Honors ARB_TIMEOUT_EN like the design.

module tb_bus_arbiter4;

  localparam int unsigned MAX_HOLD = 8;
  localparam int unsigned CNT_W    = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] din [4];
  logic [3:0]  gnt;
  logic [1:0]  gnt_idx;
  logic        busy;
  logic [15:0] out;
  logic        preempt;

  int total;
  int bad;

  bus_arbiter4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .din0    (din[0]),
    .din1    (din[1]),
    .din2    (din[2]),
    .din3    (din[3]),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .out     (out),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  int          m_owner;   // -1 = nobody
  int          m_held;    // cycles the current owner has held the bus
  int          m_last;
  bit          m_pre;
  int          m_nxt;
  logic [3:0]  m_others;

  function automatic int rr_next(input logic [3:0] mask, input int after);
    for (int k = 1; k <= 4; k++) begin
      if (mask[(after + k) % 4]) return (after + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_held  = 0;
      m_last  = 3;
      m_pre   = 1'b0;
    end else begin
      m_pre = 1'b0;
      if (m_owner < 0) begin
        m_nxt = rr_next(req, m_last);
        if (m_nxt >= 0) begin
          m_owner = m_nxt;
          m_last  = m_nxt;
          m_held  = 1;
        end
      end else if (!req[m_owner]) begin
        m_last  = m_owner;
        m_nxt   = rr_next(req, m_owner);
        m_owner = m_nxt;
        m_held  = (m_nxt >= 0) ? 1 : 0;
      end else begin
        m_others = req & ~(4'b0001 << m_owner);
        if (TO_EN && m_held == int'(MAX_HOLD) && m_others != 4'b0000) begin
          m_last  = m_owner;
          m_owner = rr_next(m_others, m_owner);
          m_held  = 1;
          m_pre   = 1'b1;
        end else begin
          m_held = m_held + 1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    req   = 4'b0000;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n  = 1'b0;
    req    = 4'b1111;
    din[0] = 16'h1111; din[1] = 16'h2222; din[2] = 16'h3333; din[3] = 16'h4444;
    tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (out !== 16'h0000) begin bad++; $display("FAIL reset_out got=%h want=0000", out); end
    total++; if (gnt_idx !== 2'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", gnt_idx); end
    total++; if (preempt !== 1'b0) begin bad++; $display("FAIL reset_preempt got=%b want=0", preempt); end
    rst_n = 1'b1;
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL reset_first_gnt got=%b want=0001", gnt); end
    total++; if (out !== 16'h1111) begin bad++; $display("FAIL reset_first_out got=%h want=1111", out); end
    req = 4'b0000;
    tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_release got=%b want=0000", gnt); end
  endtask

  task automatic test_single;
    din[2] = 16'hBEEF;
    req    = 4'b0100;
    tick();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt got=%b want=0100", gnt); end
    total++; if (gnt_idx !== 2'd2) begin bad++; $display("FAIL single_idx got=%0d want=2", gnt_idx); end
    total++; if (out !== 16'hBEEF) begin bad++; $display("FAIL single_out got=%h want=beef", out); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
    req = 4'b0000;
    tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL single_drop_gnt got=%b want=0000", gnt); end
    total++; if (out !== 16'h0000) begin bad++; $display("FAIL single_drop_out got=%h want=0000", out); end
  endtask

  task automatic test_fairness;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] want;
    do_reset();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      want = 4'b0001 << order[k];
      total++;
      if (gnt !== want || busy !== 1'b1) begin
        bad++; $display("FAIL fair_step%0d got=%b busy=%b want=%b", k, gnt, busy, want);
      end
      req = 4'b1111 ^ want;
      tick();
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_timeout;
    logic [3:0] want_g;
    logic       want_p;
    do_reset();
    req = 4'b0001;
    tick();
    for (int c = 1; c <= 12; c++) begin
      if (TO_EN) begin
        want_g = (c <= int'(MAX_HOLD)) ? 4'b0001 : 4'b1000;
        want_p = (c == int'(MAX_HOLD) + 1);
      end else begin
        want_g = 4'b0001;
        want_p = 1'b0;
      end
      total++; if (gnt !== want_g) begin bad++; $display("FAIL timeout_gnt c=%0d got=%b want=%b", c, gnt, want_g); end
      total++; if (preempt !== want_p) begin bad++; $display("FAIL timeout_pre c=%0d got=%b want=%b", c, preempt, want_p); end
      if (c == 2) req = 4'b1001;
      tick();
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_async_reset;
    do_reset();
    req = 4'b0010;
    tick();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL areset_pre got=%b want=0010", gnt); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL areset_gnt got=%b want=0000", gnt); end
    total++; if (busy !== 1'b0 || out !== 16'h0000) begin
      bad++; $display("FAIL areset_bus busy=%b out=%h want busy=0 out=0000", busy, out);
    end
    tick();
    req   = 4'b0011;
    rst_n = 1'b1;
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL areset_after got=%b want=0001", gnt); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_random;
    int         wait_cnt [4];
    logic [3:0] prev_gnt;
    logic [3:0] want_g;
    logic [15:0] want_o;
    logic [3:0] flip;
    int         shown;
    shown    = 0;
    prev_gnt = gnt;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      want_g = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      want_o = (m_owner < 0) ? 16'h0000 : din[m_owner];
      total++;
      if (gnt !== want_g || busy !== (m_owner >= 0) || preempt !== m_pre || out !== want_o ||
          (m_owner >= 0 && gnt_idx !== 2'(m_owner))) begin
        bad++;
        if (shown < 20) begin
          shown++;
          $display("FAIL rand_model cyc=%0d gnt=%b idx=%0d busy=%b pre=%b out=%h want gnt=%b pre=%b out=%h",
                   cyc, gnt, gnt_idx, busy, preempt, out, want_g, m_pre, want_o);
        end
      end
      total++;
      if ($countones(gnt) > 1 || gnt[gnt_idx] !== busy) begin
        bad++; $display("FAIL rand_onehot cyc=%0d gnt=%b idx=%0d busy=%b", cyc, gnt, gnt_idx, busy);
      end
      // starvation: grants given to others while a requester keeps waiting
      if (gnt != 4'b0000 && gnt != prev_gnt) begin
        for (int i = 0; i < 4; i++) begin
          if (gnt[i]) wait_cnt[i] = 0;
          else if (req[i]) wait_cnt[i]++;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (!req[i]) wait_cnt[i] = 0;
        total++;
        if (wait_cnt[i] > 3) begin
          bad++; $display("FAIL rand_starve cyc=%0d req%0d waited=%0d grants want<=3", cyc, i, wait_cnt[i]);
          wait_cnt[i] = 0;
        end
      end
      prev_gnt = gnt;
      for (int i = 0; i < 4; i++) flip[i] = ($urandom_range(3) == 0);
      req = req ^ flip;
      for (int i = 0; i < 4; i++) din[i] = 16'($urandom);
      tick();
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
